// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V instruction-fetch front end.
// Holds the datapath width, the NOP encoding shown when the fetch buffer is
// empty, the bit positions of the decode fields the controller consumes, and
// the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Decode field positions inside a 32-bit instruction word
  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 6;
  localparam int F3_LSB   = 12;
  localparam int F3_MSB   = 14;
  localparam int F7B5_BIT = 30;

  // FETCH : may issue a request
  // WAIT  : one read outstanding, its word will be buffered
  // DRAIN : one read outstanding, its word is stale and will be dropped
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs.
// The head entry is presented combinationally so the core sees it in the
// same cycle it becomes valid. Flush empties the buffer and wins over any
// same-cycle push or pop. A push into a full buffer is accepted only when
// a pop happens in the same cycle.
// Ports:
//   clk    in   1          clock, rising edge
//   reset  in   1          synchronous, active-low reset
//   flush  in   1          discard all entries
//   push   in   1          write wdata at the tail
//   pop    in   1          remove the head entry
//   wdata  in   WIDTH      entry to write
//   head   out  WIDTH      current head entry (undefined when empty)
//   count  out  log2(D)+1  number of stored entries
//   full   out  1          count == DEPTH
//   empty  out  1          count == 0
module fetch_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-word reads
// to instruction memory over a req/ready + rvalid interface with at most one
// read in flight, buffers returned words, and presents the head instruction
// with its PC and decode fields. A controller redirect (PC_src) flushes the
// buffer and restarts fetching at the word-aligned target.
// Ports:
//   clk          in   1     clock, rising edge
//   reset        in   1     synchronous, active-low reset
//   imem_req     out  1     read request valid (registered)
//   imem_addr    out  XLEN  read address, word aligned (registered)
//   imem_ready   in   1     memory accepts request this cycle
//   imem_rvalid  in   1     read data valid
//   imem_rdata   in   XLEN  read data
//   stall        in   1     core cannot consume head this cycle
//   PC_src       in   1     redirect to PC_target
//   PC_target    in   XLEN  redirect address
//   instr_valid  out  1     head entry valid
//   instr        out  32    head instruction, NOP when empty
//   PC           out  XLEN  PC of head, 0 when empty
//   PC_plus4     out  XLEN  PC + 4
//   op           out  7     instr[6:0]
//   func3        out  3     instr[14:12]
//   func7b5      out  1     instr[30]
module instr_fetch_unit #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            PC_src,
  input  logic [XLEN-1:0] PC_target,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic            func7b5
);

  import riscv_pkg::*;

  localparam int                CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_t      state_reg, state_next;
  logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0]   pend_addr_reg, pend_addr_next;  // address of the read in flight
  logic              req_reg, req_next;

  logic              redirect;
  logic              accept;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              full;
  logic              empty;
  logic [XLEN+31:0]  head;
  logic [XLEN-1:0]   head_pc;
  logic [31:0]       head_instr;

  // A redirect only means something while there is a head instruction.
  assign redirect = PC_src && instr_valid;
  // req_reg can only be high in FETCH, so this is the FETCH handshake.
  assign accept   = req_reg && imem_ready;
  assign pop      = instr_valid && !stall && !PC_src;
  assign push     = (state_reg == WAIT) && imem_rvalid && !redirect && (!full || pop);

  fetch_buf #(
    .WIDTH (XLEN + 32),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({pend_addr_reg, imem_rdata}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Occupancy after this edge, used to decide whether the next request fits.
  always_comb begin
    count_next = count;
    if (redirect)         count_next = '0;
    else if (push && !pop) count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    pend_addr_next = pend_addr_reg;
    case (state_reg)
      FETCH: begin
        if (accept) begin
          // A request the memory already took cannot be recalled; if a
          // redirect lands in the same cycle its data must be dropped.
          state_next     = redirect ? DRAIN : WAIT;
          pend_addr_next = fetch_pc_reg;
          fetch_pc_next  = fetch_pc_reg + XLEN'(4);
        end
      end
      WAIT: begin
        // A response coinciding with a redirect closes the read, so there
        // is nothing left to drain.
        if (imem_rvalid)   state_next = FETCH;
        else if (redirect) state_next = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (redirect) fetch_pc_next = PC_target & ~XLEN'(3);
    // Buffer space is counted with the in-flight read: a new request is
    // only made when nothing is outstanding and an entry is free.
    req_next = (state_next == FETCH) && (count_next < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= FETCH;
      fetch_pc_reg  <= RESET_PC;
      pend_addr_reg <= RESET_PC;
      req_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      pend_addr_reg <= pend_addr_next;
      req_reg       <= req_next;
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = fetch_pc_reg;

  assign head_pc     = head[XLEN+31:32];
  assign head_instr  = head[31:0];

  assign instr_valid = !empty;
  assign instr       = empty ? NOP_INSTR : head_instr;
  assign PC          = empty ? '0 : head_pc;
  assign PC_plus4    = PC + XLEN'(4);
  assign op          = instr[OP_MSB:OP_LSB];
  assign func3       = instr[F3_MSB:F3_LSB];
  assign func7b5     = instr[F7B5_BIT];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ready = 1'b1;
  logic        stall = 1'b0;
  logic        PC_src = 1'b0;
  logic [31:0] PC_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7b5;

  int checks = 0;
  int failures = 0;

  // Memory model: answers one cycle after accept, or holds the answer while
  // hold_rsp is set and delivers it on the first free cycle afterwards.
  logic        hold_rsp = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;

  assign imem_rvalid = rsp_valid;
  assign imem_rdata  = rsp_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (imem_req === 1'b1 && imem_ready === 1'b1) begin
      if (hold_rsp) begin
        pend      <= 1'b1;
        pend_addr <= imem_addr;
      end else begin
        rsp_valid <= 1'b1;
        rsp_data  <= imem_addr ^ 32'hA5A5_0000;
      end
    end else if (pend && !hold_rsp) begin
      pend      <= 1'b0;
      rsp_valid <= 1'b1;
      rsp_data  <= pend_addr ^ 32'hA5A5_0000;
    end
  end

  instr_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .PC_src      (PC_src),
    .PC_target   (PC_target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .PC          (PC),
    .PC_plus4    (PC_plus4),
    .op          (op),
    .func3       (func3),
    .func7b5     (func7b5)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0; PC_src = 1'b0; hold_rsp = 1'b0;
    repeat (3) cyc();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h want=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=00000000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h want=0", instr_valid); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h want=00000013", instr); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=00000000", PC); end
    $display("test_reset done");
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    logic [31:0] e;
    int k;
    int n;
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    exp_in[0] = 32'hA5A5_0004; exp_in[1] = 32'hA5A5_0008; exp_in[2] = 32'hA5A5_000C;
    reset = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0h want=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h want=00000000", imem_addr); end
    cyc();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL cyc2_valid got=%0h want=0", instr_valid); end
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL cyc2_addr got=%h want=00000004", imem_addr); end
    cyc();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL cyc3_valid got=%0h want=1", instr_valid); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL cyc3_pc got=%h want=00000000", PC); end
    checks++; if (instr !== 32'hA5A5_0000) begin failures++; $display("FAIL cyc3_instr got=%h want=a5a50000", instr); end
    checks++; if (PC_plus4 !== 32'h4) begin failures++; $display("FAIL cyc3_pc4 got=%h want=00000004", PC_plus4); end
    k = 0; n = 0;
    while (k < 3 && n < 12) begin
      cyc(); n++;
      if (instr_valid === 1'b1) begin
        e = exp_in[k];
        checks++; if (PC !== exp_pc[k]) begin failures++; $display("FAIL seq_pc[%0d] got=%h want=%h", k, PC, exp_pc[k]); end
        checks++; if (instr !== e) begin failures++; $display("FAIL seq_instr[%0d] got=%h want=%h", k, instr, e); end
        checks++; if (op !== e[6:0]) begin failures++; $display("FAIL seq_op[%0d] got=%h want=%h", k, op, e[6:0]); end
        k++;
      end
    end
    checks++; if (k != 3) begin failures++; $display("FAIL seq_timeout got=%0d want=3", k); end
    $display("test_first_fetch done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3];
    int k;
    int n;
    exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (PC !== 32'hC || instr_valid !== 1'b1) begin failures++; $display("FAIL stall_head[%0d] got=%h/%0h want=0000000c/1", i, PC, instr_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%0h want=0", i, imem_req); end
    end
    stall = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 12) begin
      cyc(); n++;
      if (instr_valid === 1'b1) begin
        checks++; if (PC !== exp_pc[k]) begin failures++; $display("FAIL drain_pc[%0d] got=%h want=%h", k, PC, exp_pc[k]); end
        checks++; if (instr !== (exp_pc[k] ^ 32'hA5A5_0000)) begin failures++; $display("FAIL drain_instr[%0d] got=%h", k, instr); end
        k++;
      end
    end
    checks++; if (k != 3) begin failures++; $display("FAIL drain_timeout got=%0d want=3", k); end
    $display("test_stall done");
  endtask

  task automatic test_ready_hold();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hold_req[%0d] got=%0h want=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h1C) begin failures++; $display("FAIL hold_addr[%0d] got=%h want=0000001c", i, imem_addr); end
    end
    imem_ready = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL accept_req got=%0h want=0", imem_req); end
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL accept_addr got=%h want=00000020", imem_addr); end
    cyc();
    checks++; if (instr_valid !== 1'b1 || PC !== 32'h1C) begin failures++; $display("FAIL accept_head got=%h/%0h want=0000001c/1", PC, instr_valid); end
    $display("test_ready_hold done");
  endtask

  task automatic test_redirect_drain();
    int n;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1; stall = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    stall = 1'b0;
    cyc();
    checks++; if (PC !== 32'h4) begin failures++; $display("FAIL rd_setup_pc got=%h want=00000004", PC); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL rd_setup_req got=%0h/%h want=1/00000008", imem_req, imem_addr); end
    stall = 1'b1; hold_rsp = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin failures++; $display("FAIL rd_wait got=%0h/%0h want=0/1", imem_req, instr_valid); end
    PC_src = 1'b1; PC_target = 32'h100;
    cyc();
    PC_src = 1'b0; hold_rsp = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin failures++; $display("FAIL rd_flush got=%0h/%h want=0/00000013", instr_valid, instr); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("FAIL rd_drain got=%0h/%h want=0/00000100", imem_req, imem_addr); end
    cyc();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rd_stale got=%0h/%0h want=0/0", instr_valid, imem_req); end
    cyc();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rd_discard got=%0h want=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rd_refetch got=%0h/%h want=1/00000100", imem_req, imem_addr); end
    n = 0;
    do begin cyc(); n++; end while (instr_valid !== 1'b1 && n < 8);
    checks++; if (instr_valid !== 1'b1 || PC !== 32'h100) begin failures++; $display("FAIL rd_target got=%h/%0h want=00000100/1", PC, instr_valid); end
    checks++; if (instr !== 32'hA5A5_0100) begin failures++; $display("FAIL rd_target_instr got=%h want=a5a50100", instr); end
    $display("test_redirect_drain done");
  endtask

  task automatic test_align_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    int k;
    int n;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    exp_in[0] = 32'h5A5A_FFF8; exp_in[1] = 32'h5A5A_FFFC; exp_in[2] = 32'hA5A5_0000;
    imem_ready = 1'b0; PC_src = 1'b1; PC_target = 32'h0000_0103;
    cyc();
    imem_ready = 1'b1; PC_src = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL align_addr got=%0h/%h want=1/00000100", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL align_flush got=%0h want=0", instr_valid); end
    n = 0;
    do begin cyc(); n++; end while (instr_valid !== 1'b1 && n < 8);
    checks++; if (instr_valid !== 1'b1 || PC !== 32'h100) begin failures++; $display("FAIL align_head got=%h/%0h want=00000100/1", PC, instr_valid); end
    imem_ready = 1'b0; PC_src = 1'b1; PC_target = 32'hFFFF_FFF8;
    cyc();
    imem_ready = 1'b1; PC_src = 1'b0; stall = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_start got=%0h/%h want=1/fffffff8", imem_req, imem_addr); end
    k = 0; n = 0;
    while (k < 3 && n < 16) begin
      cyc(); n++;
      if (instr_valid === 1'b1) begin
        checks++; if (PC !== exp_pc[k]) begin failures++; $display("FAIL wrap_pc[%0d] got=%h want=%h", k, PC, exp_pc[k]); end
        checks++; if (instr !== exp_in[k]) begin failures++; $display("FAIL wrap_instr[%0d] got=%h want=%h", k, instr, exp_in[k]); end
        if (k == 0) begin
          checks++; if (op !== 7'h78) begin failures++; $display("FAIL wrap_op got=%h want=78", op); end
          checks++; if (func3 !== 3'h7) begin failures++; $display("FAIL wrap_func3 got=%h want=7", func3); end
          checks++; if (func7b5 !== 1'b1) begin failures++; $display("FAIL wrap_func7b5 got=%0h want=1", func7b5); end
        end
        if (k == 1) begin
          checks++; if (PC_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h want=00000000", PC_plus4); end
        end
        k++;
      end
    end
    checks++; if (k != 3) begin failures++; $display("FAIL wrap_timeout got=%0d want=3", k); end
    $display("test_align_wrap done");
  endtask

  task automatic test_midop_reset();
    stall = 1'b1; hold_rsp = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin failures++; $display("FAIL mr_wait got=%0h/%0h want=0/1", imem_req, instr_valid); end
    reset = 1'b0;
    cyc();
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin failures++; $display("FAIL mr_flush got=%0h/%h want=0/00000013", instr_valid, instr); end
    checks++; if (imem_req !== 1'b0 || PC !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL mr_state got=%0h/%h/%h want=0/0/0", imem_req, PC, imem_addr); end
    reset = 1'b1; hold_rsp = 1'b0; stall = 1'b0;
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mr_restart got=%0h/%h want=1/00000000", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mr_empty got=%0h want=0", instr_valid); end
    cyc();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mr_late_ignored got=%0h want=0", instr_valid); end
    cyc();
    checks++; if (instr_valid !== 1'b1 || PC !== 32'h0) begin failures++; $display("FAIL mr_head got=%h/%0h want=00000000/1", PC, instr_valid); end
    checks++; if (instr !== 32'hA5A5_0000) begin failures++; $display("FAIL mr_instr got=%h want=a5a50000", instr); end
    $display("test_midop_reset done");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_ready_hold();
    test_redirect_drain();
    test_align_wrap();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
